// File: rtl/bb_ctrl_defs.sv
// Shared state encodings, direction codes and counter width for the pad-group
// turnaround controller.
package bb_ctrl_defs;

  localparam int GAP_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RDONE  = 3'd4
  } bb_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_WR   = 2'd1,
    DIR_RD   = 2'd2
  } bb_dir_e;

endpackage

// File: rtl/bb_rr_arb2.sv
// Two-requester round-robin arbiter; req[0] is write, req[1] is read.
// The grant is combinational; the fairness pointer moves only on adv.
module bb_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic favour_rd;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = favour_rd ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After any grant, favour whichever requester did not win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      favour_rd <= 1'b0;
    end else if (adv && (gnt != 2'b00)) begin
      favour_rd <= gnt[0];
    end
  end

endmodule

// File: rtl/bb_turnaround_ctrl.sv
// Sequences one bidirectional pad group between a write and a read requester,
// inserting a bus-release gap whenever the drive direction changes.
//
// Handshake: WR_REQ/RD_REQ are levels sampled only in IDLE (no ready signal);
// WR_ACK and RD_VALID are single-cycle completion pulses with no back-pressure.
module bb_turnaround_ctrl
  import bb_ctrl_defs::*;
#(
  parameter int WIDTH   = 8,
  parameter int TURN    = 2,
  parameter int RD_WAIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_REQ,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_ACK,
  input  logic             RD_REQ,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic [WIDTH-1:0] PAD_I,
  output logic             PAD_T,
  input  logic [WIDTH-1:0] PAD_O,
  output logic             BUSY,
  output bb_state_e        state_dbg
);

  localparam logic [GAP_W-1:0] TURN_C    = GAP_W'(TURN);
  localparam logic [GAP_W-1:0] RD_WAIT_C = GAP_W'(RD_WAIT);

  bb_state_e        state;
  bb_state_e        state_next;
  bb_dir_e          last_dir;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] wait_cnt;
  logic             lock_wr;
  logic [1:0]       gnt;
  logic             arb_adv;

  assign state_dbg = state;
  assign arb_adv   = (state == ST_IDLE) && (WR_REQ || RD_REQ);

  bb_rr_arb2 u_arb (
    .clk (CLK),
    .rst (RST),
    .req ({RD_REQ, WR_REQ}),
    .adv (arb_adv),
    .gnt (gnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (gnt[0]) begin
          state_next = (last_dir == DIR_RD && gap < TURN_C) ? ST_GAP : ST_DRIVE;
        end else if (gnt[1]) begin
          state_next = (last_dir == DIR_WR && gap < TURN_C) ? ST_GAP : ST_SAMPLE;
        end
      end
      ST_GAP: begin
        if (gap == TURN_C) begin
          state_next = lock_wr ? ST_DRIVE : ST_SAMPLE;
        end
      end
      ST_DRIVE:  state_next = ST_IDLE;
      ST_SAMPLE: begin
        if (wait_cnt == RD_WAIT_C) begin
          state_next = ST_RDONE;
        end
      end
      ST_RDONE:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a flop that the
  // asynchronous reset can force to its released value immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_dir <= DIR_NONE;
      gap      <= TURN_C;
      wait_cnt <= '0;
      lock_wr  <= 1'b0;
      PAD_I    <= '0;
      PAD_T    <= 1'b1;
      WR_ACK   <= 1'b0;
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
      BUSY     <= 1'b0;
    end else begin
      if (arb_adv) begin
        lock_wr <= gnt[0];
      end

      // Counts released cycles since the last transfer, saturating at TURN.
      if (state == ST_IDLE || state == ST_GAP) begin
        gap <= (gap >= TURN_C) ? TURN_C : gap + 1'b1;
      end else begin
        gap <= '0;
      end

      wait_cnt <= (state == ST_SAMPLE) ? wait_cnt + 1'b1 : GAP_W'(1);

      if (state_next == ST_DRIVE) begin
        last_dir <= DIR_WR;
        PAD_I    <= WR_DATA;
      end else if (state_next == ST_SAMPLE) begin
        last_dir <= DIR_RD;
      end

      if (state == ST_SAMPLE && state_next == ST_RDONE) begin
        RD_DATA <= PAD_O;
      end

      PAD_T    <= (state_next != ST_DRIVE);
      WR_ACK   <= (state_next == ST_DRIVE);
      RD_VALID <= (state_next == ST_RDONE);
      BUSY     <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: doc/bb_turnaround_ctrl.md
# bb_turnaround_ctrl

Sequences one bidirectional pad group (an array of WIDTH BB cells) between a local write requester and a local read requester. Drives the cells' I and T inputs and samples their O outputs. Arbitrates between the two requesters round-robin. Inserts a guaranteed bus-release gap whenever the drive direction changes, so the pad never sees contention between our driver and the external device.

## Interface
Parameters:
- WIDTH, 8, pad group width in bits.
- TURN, 2, minimum turnaround count on a direction change; legal range 1..15.
- RD_WAIT, 1, number of released cycles before the pads are sampled on a read; legal range 1..15.

Ports:
- CLK  input  1  single clock; all logic on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- WR_REQ  input  1  write request, level; sampled only in IDLE.
- WR_DATA  input  WIDTH  write data; must be stable while WR_REQ is high.
- WR_ACK  output  1  one-cycle pulse in the cycle the data is on the pads.
- RD_REQ  input  1  read request, level; sampled only in IDLE.
- RD_DATA  output  WIDTH  captured pad value; holds until the next capture.
- RD_VALID  output  1  one-cycle pulse; RD_DATA is valid in that cycle.
- PAD_I  output  WIDTH  to BB.I.
- PAD_T  output  1  to all BB.T; 1 = released (tristate), 0 = driving.
- PAD_O  input  WIDTH  from BB.O.
- BUSY  output  1  high in any state other than IDLE.

## Operation
- All outputs are registered.
- States:
  - IDLE: PAD_T=1.
  - GAP: PAD_T=1, grant locked.
  - DRIVE: PAD_T=0, WR_ACK=1.
  - SAMPLE: PAD_T=1, counts RD_WAIT cycles.
  - RDONE: PAD_T=1, RD_VALID=1.
- last_dir register, values NONE/WR/RD:
  - set to WR on entering DRIVE, and to RD on entering SAMPLE.
  - reset value NONE.
- gap counter:
  - 4 bits, saturates at TURN, reset value TURN.
  - increments at each edge that ends an IDLE or GAP cycle.
  - cleared in DRIVE, SAMPLE and RDONE.
- Arbitration in IDLE:
  - If only one request is high, it wins.
  - If both are high, the round-robin pointer decides; the pointer reset value favours write.
  - The pointer flips to favour the other requester after each grant.
- Grant to write:
  - If last_dir=RD and gap<TURN, go to GAP; otherwise go to DRIVE.
  - Register PAD_I<=WR_DATA on entry to DRIVE.
- Grant to read:
  - If last_dir=WR and gap<TURN, go to GAP; otherwise go to SAMPLE.
- GAP: when gap==TURN, proceed to the locked grant's state. Requests are ignored in GAP.
- DRIVE: lasts 1 cycle, then IDLE.
- SAMPLE: lasts RD_WAIT cycles. PAD_O is captured into RD_DATA at the edge ending the last SAMPLE cycle; next state is RDONE.
- RDONE: lasts 1 cycle, then IDLE.
- Same-direction back-to-back transfers need no gap.
- A request still high in the ACK/VALID cycle is not seen, because it is sampled only in IDLE. A request held into the following IDLE cycle is a new transfer.
- PAD_I holds its last driven value while released.

## Timing
- Reset values: PAD_T=1, PAD_I=0, WR_ACK=0, RD_VALID=0, RD_DATA=0, BUSY=0, state IDLE.
- Asserting RST mid-transfer releases the pads asynchronously with PAD_T=1. No ACK/VALID is issued for the aborted transfer.
- Write latency, no gap needed:
  - WR_REQ seen in IDLE cycle n.
  - DRIVE with WR_ACK=1 in cycle n+1.
  - IDLE in cycle n+2.
  - Minimum write interval is 2 cycles.
- Read latency, no gap needed:
  - RD_REQ seen in IDLE cycle n.
  - SAMPLE in cycles n+1..n+RD_WAIT.
  - RDONE with RD_VALID=1 in cycle n+RD_WAIT+1.
- Direction change: at least TURN+1 consecutive released cycles before the new direction starts. The IDLE cycle plus TURN GAP cycles are counted from the end of DRIVE/RDONE.

## Structure
- Shared definitions file (bb_ctrl_defs): state encodings (3 bits), last_dir codes, and the gap counter width constant of 4.
- Sub-module bb_rr_arb2: two-requester round-robin arbiter.
  - Inputs: req[1:0] and an advance strobe.
  - Outputs: a one-hot grant.
- The FSM, counters and pad registers live in the top level.

## Test plan
All scenarios use WIDTH=8, TURN=2, RD_WAIT=1.
- Reset: hold RST, then release -> PAD_T=1, PAD_I=0, RD_DATA=0, WR_ACK=RD_VALID=BUSY=0.
- Single write 8'hA5, WR_REQ high in cycle 0 -> cycle 1: PAD_T=0, PAD_I=A5, WR_ACK=1; cycle 2: PAD_T=1.
- Write A5 then RD_REQ held from cycle 2, external device driving 8'h3C -> GAP in cycles 3-4, SAMPLE in cycle 5, RDONE in cycle 6 with RD_DATA=3C and RD_VALID=1.
- WR_REQ and RD_REQ both high from reset -> write granted first, then read after the gap. On the next tie, read is granted first.
- RD_REQ held continuously, PAD_O=8'h11 then 8'h22 -> RD_VALID pulses every 3 cycles with no GAP states, returning 11 then 22.
- RST asserted mid-DRIVE, between clock edges -> PAD_T=1 immediately without waiting for a clock edge; WR_ACK=0; next grant needs no gap because last_dir=NONE.
